gshare_branch_predictor: RTL and testbench
==========================================

// Module: gshare_branch_predictor
// PURPOSE
//  Parametrised direction predictor for the IF stage: table of CTR_BITS saturating counters
//  indexed by PC bits, optionally XOR-hashed with a global history register (gshare).
//  Predicts combinationally each cycle; trains from EX-stage branch resolution.
//  Self-initialises its table after reset and counts mispredictions for perf monitoring.
// PARAMETERS
//  INDEX_BITS  8  log2 of table entries (256 default)
//  CTR_BITS    2  counter width, >=2; MSB = predict taken
//  GHR_BITS    8  global history length, 1..INDEX_BITS
//  USE_GSHARE  1  1: index = pc_bits ^ ghr (ghr zero-extended); 0: index = pc_bits (bimodal)
//  PC_LSB      2  lowest PC bit used; pc_bits = pred_pc[PC_LSB+INDEX_BITS-1:PC_LSB]
// PORTS
//  clk             in   1           clock; all state updates on rising edge
//  rst_n           in   1           asynchronous reset, active-low
//  pred_pc         in   32          fetch PC
//  pred_taken      out  1           predicted direction (combinational)
//  pred_index      out  INDEX_BITS  table index used; pipelined with the branch to EX
//  ready           out  1           0 while table initialisation runs
//  upd_valid       in   1           a conditional branch resolved this cycle
//  upd_index       in   INDEX_BITS  pred_index that branch was predicted with
//  upd_taken       in   1           actual outcome
//  upd_mispredict  in   1           EX found prediction wrong
//  mispredict_cnt  out  32          mispredictions since reset, saturating
// BEHAVIOUR
//  Reset (async, rst_n=0): ghr=0, mispredict_cnt=0, ready=0, init_ptr=0, FSM=INIT.
//   Table contents are not reset asynchronously; INIT sweep writes them.
//  FSM INIT: one entry per cycle, table[init_ptr] <= WNT = 2^(CTR_BITS-1)-1 (2'b01);
//   init_ptr increments; after writing entry 2^INDEX_BITS-1 -> READY next edge.
//   First edge after rst_n rises writes entry 0; ready=1 after exactly 2^INDEX_BITS edges.
//   During INIT: pred_taken=0, upd_valid ignored (no table/ghr/counter change).
//  FSM READY: stays until rst_n asserted. Reset mid-INIT or in READY restarts sweep from 0.
//  Prediction: pred_index per USE_GSHARE from pred_pc and current ghr;
//   pred_taken = table[pred_index][CTR_BITS-1] when ready. Pure combinational, 0 latency.
//  Update (READY, upd_valid=1), at rising edge:
//   taken & ctr!=max -> ctr+1; !taken & ctr!=0 -> ctr-1; else unchanged (saturate).
//   ghr <= {ghr[GHR_BITS-2:0], upd_taken} (GHR_BITS=1: ghr<=upd_taken). Non-speculative.
//   upd_mispredict=1 -> mispredict_cnt+1, holds at 32'hFFFF_FFFF.
//  Same-cycle predict and update on same index: prediction sees pre-update value (no
//   bypass); write visible next cycle. Prediction in same cycle as ghr shift uses old ghr.
//  One update per cycle max; upd_index used verbatim, never recomputed from a PC.
//  Table is single-write: init write and update write never coincide (FSM-exclusive).
// TESTING
//  Reset, INDEX_BITS=8: ready=0 for 256 cycles, 1 at 256th edge; every entry reads 2'b01,
//   pred_taken=0 for all PCs.
//  Bimodal (USE_GSHARE=0), pc=0x40: 3 taken updates -> 01,10,11,11; pred_taken 0,1,1,1;
//   then 1 not-taken -> 10, still taken (hysteresis); 2 more -> 00, held at 00.
//  Gshare: pc=0x100 with ghr=0x00 vs ghr=0xFF -> pred_index 0x40 vs 0xBF; training one
//   leaves the other entry at 01.
//  Update during INIT (upd_valid=1, upd_mispredict=1): no ghr, table or mispredict_cnt change.
//  Assert rst_n=0 at init cycle 100: ready drops at once, ghr=0, sweep restarts, ready
//   256 edges after release.
//  Same-cycle predict+update on index 0x12 (ctr 01, taken): pred_taken=0 that cycle, 1 next;
//   mispredict_cnt preloaded near max saturates at 0xFFFFFFFF.

Source files
------------

// File: rtl/gshare_branch_predictor.sv
// rtl/gshare_branch_predictor.sv - gshare/bimodal direction predictor with self-initialising counter table
module gshare_branch_predictor #(
  parameter int INDEX_BITS = 8,
  parameter int CTR_BITS   = 2,
  parameter int GHR_BITS   = 8,
  parameter bit USE_GSHARE = 1'b1,
  parameter int PC_LSB     = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [31:0]           pred_pc,
  output logic                  pred_taken,
  output logic [INDEX_BITS-1:0] pred_index,
  output logic                  ready,
  input  logic                  upd_valid,
  input  logic [INDEX_BITS-1:0] upd_index,
  input  logic                  upd_taken,
  input  logic                  upd_mispredict,
  output logic [31:0]           mispredict_cnt
);

  localparam int ENTRIES = 1 << INDEX_BITS;
  // Weakly-not-taken: MSB clear, all lower bits set.
  localparam logic [CTR_BITS-1:0] CTR_WNT = {1'b0, {(CTR_BITS-1){1'b1}}};
  localparam logic [CTR_BITS-1:0] CTR_MAX = '1;

  typedef enum logic {ST_INIT, ST_READY} state_t;

  state_t                state_q, state_d;
  logic [INDEX_BITS-1:0] init_ptr_q, init_ptr_d;
  logic [GHR_BITS-1:0]   ghr_q, ghr_d;
  logic [31:0]           cnt_q, cnt_d;
  logic [CTR_BITS-1:0]   table_q [ENTRIES];

  logic                  tbl_we;
  logic [INDEX_BITS-1:0] tbl_waddr;
  logic [CTR_BITS-1:0]   tbl_wdata;
  logic [CTR_BITS-1:0]   upd_ctr;
  logic [INDEX_BITS-1:0] pc_bits;
  logic [INDEX_BITS-1:0] ghr_ext;
  logic [GHR_BITS-1:0]   ghr_shift;
  logic                  unused_pc;

  // Only a window of the PC indexes the table; the rest is deliberately ignored.
  assign unused_pc = ^pred_pc;
  assign pc_bits   = pred_pc[PC_LSB+INDEX_BITS-1:PC_LSB];

  // Zero-extend the history to the index width.
  always_comb begin
    ghr_ext                = '0;
    ghr_ext[GHR_BITS-1:0]  = ghr_q;
  end

  if (GHR_BITS == 1) begin : g_ghr1
    assign ghr_shift = upd_taken;
  end else begin : g_ghrn
    assign ghr_shift = {ghr_q[GHR_BITS-2:0], upd_taken};
  end

  // Prediction reads the table as it stands before any same-cycle update.
  assign pred_index     = USE_GSHARE ? (pc_bits ^ ghr_ext) : pc_bits;
  assign ready          = (state_q == ST_READY);
  assign pred_taken     = ready & table_q[pred_index][CTR_BITS-1];
  assign mispredict_cnt = cnt_q;
  assign upd_ctr        = table_q[upd_index];

  // Next-state: init sweep owns the table write port until READY, then resolved branches do.
  always_comb begin
    state_d    = state_q;
    init_ptr_d = init_ptr_q;
    ghr_d      = ghr_q;
    cnt_d      = cnt_q;
    tbl_we     = 1'b0;
    tbl_waddr  = init_ptr_q;
    tbl_wdata  = CTR_WNT;
    unique case (state_q)
      ST_INIT: begin
        tbl_we     = 1'b1;
        init_ptr_d = init_ptr_q + 1'b1;
        if (init_ptr_q == '1) state_d = ST_READY;
      end
      ST_READY: begin
        if (upd_valid) begin
          tbl_we    = 1'b1;
          tbl_waddr = upd_index;
          tbl_wdata = upd_ctr;
          if (upd_taken && (upd_ctr != CTR_MAX)) tbl_wdata = upd_ctr + 1'b1;
          else if (!upd_taken && (upd_ctr != '0)) tbl_wdata = upd_ctr - 1'b1;
          ghr_d = ghr_shift;
          if (upd_mispredict && (cnt_q != '1)) cnt_d = cnt_q + 32'd1;
        end
      end
      default: ;
    endcase
  end

  // Control state, history and perf counter; reset restarts the sweep.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_INIT;
      init_ptr_q <= '0;
      ghr_q      <= '0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      init_ptr_q <= init_ptr_d;
      ghr_q      <= ghr_d;
      cnt_q      <= cnt_d;
    end
  end

  // Counter table: no reset, contents come from the init sweep.
  always_ff @(posedge clk) begin
    if (tbl_we) table_q[tbl_waddr] <= tbl_wdata;
  end

endmodule

// File: tb/tb_gshare_branch_predictor.sv
// tb/tb_gshare_branch_predictor.sv - directed self-checking bench for gshare_branch_predictor
module tb_gshare_branch_predictor;

  logic        clk;
  logic        rst_n;

  logic [31:0] g_pc;
  logic        g_taken;
  logic [7:0]  g_index;
  logic        g_ready;
  logic        g_uv;
  logic [7:0]  g_ui;
  logic        g_ut;
  logic        g_um;
  logic [31:0] g_cnt;

  logic [31:0] b_pc;
  logic        b_taken;
  logic [7:0]  b_index;
  logic        b_ready;
  logic        b_uv;
  logic [7:0]  b_ui;
  logic        b_ut;
  logic        b_um;
  logic [31:0] b_cnt;

  int n_checks;
  int n_fail;

  gshare_branch_predictor #(
    .INDEX_BITS(8), .CTR_BITS(2), .GHR_BITS(8), .USE_GSHARE(1'b1), .PC_LSB(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .pred_pc(g_pc), .pred_taken(g_taken), .pred_index(g_index),
    .ready(g_ready), .upd_valid(g_uv), .upd_index(g_ui), .upd_taken(g_ut),
    .upd_mispredict(g_um), .mispredict_cnt(g_cnt)
  );

  gshare_branch_predictor #(
    .INDEX_BITS(8), .CTR_BITS(2), .GHR_BITS(8), .USE_GSHARE(1'b0), .PC_LSB(2)
  ) dut_bm (
    .clk(clk), .rst_n(rst_n), .pred_pc(b_pc), .pred_taken(b_taken), .pred_index(b_index),
    .ready(b_ready), .upd_valid(b_uv), .upd_index(b_ui), .upd_taken(b_ut),
    .upd_mispredict(b_um), .mispredict_cnt(b_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic upd_g(input logic [7:0] idx, input logic t, input logic m);
    @(negedge clk);
    g_uv = 1'b1; g_ui = idx; g_ut = t; g_um = m;
    @(negedge clk);
    g_uv = 1'b0; g_ut = 1'b0; g_um = 1'b0;
  endtask

  task automatic upd_b(input logic [7:0] idx, input logic t, input logic m);
    @(negedge clk);
    b_uv = 1'b1; b_ui = idx; b_ut = t; b_um = m;
    @(negedge clk);
    b_uv = 1'b0; b_ut = 1'b0; b_um = 1'b0;
  endtask

  task automatic test_reset();
    int bad;
    @(negedge clk);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (g_ready !== 1'b0 || b_ready !== 1'b0) begin
      n_fail++; $display("FAIL reset_ready: got %b/%b want 0/0", g_ready, b_ready);
    end
    n_checks++;
    if (g_cnt !== 32'd0 || dut.ghr_q !== 8'd0) begin
      n_fail++; $display("FAIL reset_state: cnt=%h ghr=%h want 0/0", g_cnt, dut.ghr_q);
    end
    rst_n = 1'b1;
    for (int i = 1; i <= 256; i++) begin
      @(posedge clk); #1;
      if (i == 255) begin
        n_checks++;
        if (g_ready !== 1'b0 || b_ready !== 1'b0) begin
          n_fail++; $display("FAIL ready_early: edge 255 got %b/%b want 0/0", g_ready, b_ready);
        end
      end
      if (i == 256) begin
        n_checks++;
        if (g_ready !== 1'b1 || b_ready !== 1'b1) begin
          n_fail++; $display("FAIL ready_late: edge 256 got %b/%b want 1/1", g_ready, b_ready);
        end
      end
    end
    bad = 0;
    for (int e = 0; e < 256; e++) begin
      if (dut.table_q[e] !== 2'b01) bad++;
      if (dut_bm.table_q[e] !== 2'b01) bad++;
    end
    n_checks++;
    if (bad != 0) begin
      n_fail++; $display("FAIL init_table: %0d entries not 01, want 0", bad);
    end
    bad = 0;
    for (int p = 0; p < 1024; p++) begin
      g_pc = p * 4; b_pc = p * 4; #1;
      if (g_taken !== 1'b0 || b_taken !== 1'b0) bad++;
    end
    n_checks++;
    if (bad != 0) begin
      n_fail++; $display("FAIL init_pred: %0d PCs predicted taken, want 0", bad);
    end
  endtask

  task automatic test_update_during_init();
    @(negedge clk);
    rst_n = 1'b0;
    g_uv = 1'b1; g_ui = 8'h00; g_ut = 1'b1; g_um = 1'b1;
    b_uv = 1'b1; b_ui = 8'h00; b_ut = 1'b1; b_um = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (256) @(negedge clk);
    g_uv = 1'b0; g_ut = 1'b0; g_um = 1'b0;
    b_uv = 1'b0; b_ut = 1'b0; b_um = 1'b0;
    n_checks++;
    if (g_ready !== 1'b1) begin
      n_fail++; $display("FAIL init_upd_ready: got %b want 1", g_ready);
    end
    n_checks++;
    if (dut.ghr_q !== 8'd0 || dut_bm.ghr_q !== 8'd0) begin
      n_fail++; $display("FAIL init_upd_ghr: got %h/%h want 00/00", dut.ghr_q, dut_bm.ghr_q);
    end
    n_checks++;
    if (g_cnt !== 32'd0 || b_cnt !== 32'd0) begin
      n_fail++; $display("FAIL init_upd_cnt: got %h/%h want 0/0", g_cnt, b_cnt);
    end
    n_checks++;
    if (dut.table_q[0] !== 2'b01 || dut_bm.table_q[0] !== 2'b01) begin
      n_fail++; $display("FAIL init_upd_table: got %b/%b want 01/01", dut.table_q[0], dut_bm.table_q[0]);
    end
  endtask

  task automatic test_bimodal();
    logic       seq_t  [7] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    logic [1:0] seq_c  [7] = '{2'b10, 2'b11, 2'b11, 2'b10, 2'b01, 2'b00, 2'b00};
    logic       seq_p  [7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    b_pc = 32'h40; #1;
    n_checks++;
    if (b_index !== 8'h10 || b_taken !== 1'b0) begin
      n_fail++; $display("FAIL bm_start: idx=%h taken=%b want 10/0", b_index, b_taken);
    end
    for (int k = 0; k < 7; k++) begin
      upd_b(8'h10, seq_t[k], 1'b0);
      #1;
      n_checks++;
      if (dut_bm.table_q[8'h10] !== seq_c[k] || b_taken !== seq_p[k]) begin
        n_fail++;
        $display("FAIL bm_step%0d: ctr=%b taken=%b want %b/%b", k, dut_bm.table_q[8'h10], b_taken, seq_c[k], seq_p[k]);
      end
    end
  endtask

  task automatic test_gshare();
    g_pc = 32'h100; #1;
    n_checks++;
    if (g_index !== 8'h40 || g_taken !== 1'b0) begin
      n_fail++; $display("FAIL gs_idx0: idx=%h taken=%b want 40/0", g_index, g_taken);
    end
    repeat (8) upd_g(8'h05, 1'b1, 1'b0);
    #1;
    n_checks++;
    if (dut.ghr_q !== 8'hFF || g_index !== 8'hBF || g_taken !== 1'b0) begin
      n_fail++; $display("FAIL gs_idxff: ghr=%h idx=%h taken=%b want FF/BF/0", dut.ghr_q, g_index, g_taken);
    end
    repeat (2) upd_g(8'hBF, 1'b1, 1'b0);
    #1;
    n_checks++;
    if (g_taken !== 1'b1 || dut.table_q[8'hBF] !== 2'b11) begin
      n_fail++; $display("FAIL gs_train: taken=%b ctr=%b want 1/11", g_taken, dut.table_q[8'hBF]);
    end
    n_checks++;
    if (dut.table_q[8'h40] !== 2'b01) begin
      n_fail++; $display("FAIL gs_other: ctr=%b want 01", dut.table_q[8'h40]);
    end
    repeat (8) upd_g(8'h06, 1'b0, 1'b0);
    #1;
    n_checks++;
    if (g_index !== 8'h40 || g_taken !== 1'b0 || g_cnt !== 32'd0) begin
      n_fail++; $display("FAIL gs_back: idx=%h taken=%b cnt=%h want 40/0/0", g_index, g_taken, g_cnt);
    end
  endtask

  task automatic test_same_cycle();
    @(negedge clk);
    force dut_bm.cnt_q = 32'hFFFF_FFFE;
    #1;
    release dut_bm.cnt_q;
    @(negedge clk);
    b_pc = 32'h48; b_ui = 8'h12; b_ut = 1'b1; b_um = 1'b1; b_uv = 1'b1;
    #1;
    n_checks++;
    if (b_index !== 8'h12 || b_taken !== 1'b0) begin
      n_fail++; $display("FAIL same_cycle_pre: idx=%h taken=%b want 12/0", b_index, b_taken);
    end
    @(negedge clk);
    b_uv = 1'b0; b_ut = 1'b0; b_um = 1'b0;
    #1;
    n_checks++;
    if (b_taken !== 1'b1) begin
      n_fail++; $display("FAIL same_cycle_post: taken=%b want 1", b_taken);
    end
    n_checks++;
    if (b_cnt !== 32'hFFFF_FFFF) begin
      n_fail++; $display("FAIL cnt_reach_max: got %h want FFFFFFFF", b_cnt);
    end
    upd_b(8'h13, 1'b0, 1'b1);
    upd_b(8'h13, 1'b0, 1'b1);
    #1;
    n_checks++;
    if (b_cnt !== 32'hFFFF_FFFF) begin
      n_fail++; $display("FAIL cnt_saturate: got %h want FFFFFFFF", b_cnt);
    end
  endtask

  task automatic test_reset_mid_init();
    int n;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (g_ready !== 1'b0 || b_ready !== 1'b0 || dut_bm.ghr_q !== 8'd0 || b_cnt !== 32'd0) begin
      n_fail++;
      $display("FAIL async_reset: ready=%b/%b ghr=%h cnt=%h want 0/0/00/0", g_ready, b_ready, dut_bm.ghr_q, b_cnt);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (100) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (g_ready !== 1'b0 || dut.init_ptr_q !== 8'd0) begin
      n_fail++; $display("FAIL mid_init_reset: ready=%b ptr=%h want 0/00", g_ready, dut.init_ptr_q);
    end
    @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    while (g_ready !== 1'b1 && n < 400) begin
      @(posedge clk); #1;
      n++;
    end
    n_checks++;
    if (n != 256 || b_ready !== 1'b1) begin
      n_fail++; $display("FAIL restart_sweep: ready after %0d edges (bm ready=%b) want 256/1", n, b_ready);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n = 1'b0;
    g_pc = 32'h0; g_uv = 1'b0; g_ui = 8'h0; g_ut = 1'b0; g_um = 1'b0;
    b_pc = 32'h0; b_uv = 1'b0; b_ui = 8'h0; b_ut = 1'b0; b_um = 1'b0;
    test_reset();
    test_update_during_init();
    test_bimodal();
    test_gshare();
    test_same_cycle();
    test_reset_mid_init();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
